tensor_result_collector: RTL and testbench

Receive-side counterpart of the 4x4x4 crossbar tensor unit's result port. The tensor unit emits one 4x16-bit result row per cycle for 4 cycles. This block captures the 4 beats into a 4x4 buffer, converts each element to OUT_W bits, and drains them one element per cycle, row-major, over a valid/ready stream to the downstream writeback or host logic.

---
 rtl/tensor_result_collector_if.sv | 50 +++++
 rtl/tensor_result_collector.sv | 179 +++++++++++++++++
 tb/tb_tensor_result_collector.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_result_collector_if.sv
// Stream bundle for tensor_result_collector: beat-input side from the tensor unit
// and the element-output valid/ready stream towards writeback.
interface tensor_result_collector_if #(
  parameter int unsigned OUT_W = 8
) ();

  logic             in_valid;
  logic [15:0]      in_col_0;
  logic [15:0]      in_col_1;
  logic [15:0]      in_col_2;
  logic [15:0]      in_col_3;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_row;
  logic [1:0]       out_col;
  logic             out_last;

  // Environment side: tensor controller plus downstream consumer.
  modport master (
    output in_valid,
    output in_col_0,
    output in_col_1,
    output in_col_2,
    output in_col_3,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last
  );

  // Collector side.
  modport slave (
    input  in_valid,
    input  in_col_0,
    input  in_col_1,
    input  in_col_2,
    input  in_col_3,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last
  );

endinterface

// File: rtl/tensor_result_collector.sv
// Collects four 4x16-bit result beats into a 4x4 buffer and drains it row-major, one
// element per handshake. Define COLLECT_SAT_EN for saturating conversion plus sat_flag.
module tensor_result_collector #(
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  tensor_result_collector_if.slave io,
  output logic                   busy,
  output logic                   overflow,
  input  logic                   clear_ovf,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef COLLECT_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_DRAIN   = 1'b1;

  logic                   state_q, state_d;
  logic [1:0]             beat_cnt_q, beat_cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [OUT_W-1:0]       buf_q [16];
  logic [OUT_W-1:0]       buf_d [16];
  logic                   overflow_q, overflow_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

  logic [15:0]            col  [4];
  logic [OUT_W-1:0]       conv [4];
  logic [3:0]             clamp;

  logic                   hs;
  logic                   last_hs;
  logic                   write_en;
  logic [1:0]             write_row;
  logic                   ovf_set;

  assign col[0] = io.in_col_0;
  assign col[1] = io.in_col_1;
  assign col[2] = io.in_col_2;
  assign col[3] = io.in_col_3;

  // Conversion happens on capture so the buffer only stores OUT_W bits per element.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      conv[c]  = col[c][OUT_W-1:0];
      clamp[c] = 1'b0;
`ifdef COLLECT_SAT_EN
      if ((col[c] >> OUT_W) != 16'd0) begin
        conv[c]  = '1;
        clamp[c] = 1'b1;
      end
`endif
    end
  end

`ifndef COLLECT_SAT_EN
  logic unused_col_hi;
  assign unused_col_hi = ^{col[0], col[1], col[2], col[3], clamp};
`endif

  assign hs      = (state_q == ST_DRAIN) && io.out_ready;
  assign last_hs = hs && (idx_q == 4'hF);

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    write_en      = 1'b0;
    write_row     = beat_cnt_q;
    ovf_set       = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (io.in_valid) begin
          write_en   = 1'b1;
          beat_cnt_d = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (hs) begin
          idx_d = idx_q + 4'd1;
        end
        if (last_hs) begin
          state_d       = ST_COLLECT;
          frame_count_d = frame_count_q + 1'b1;
          // A beat arriving with the final handshake opens the next frame.
          if (io.in_valid) begin
            write_en   = 1'b1;
            write_row  = 2'd0;
            beat_cnt_d = 2'd1;
          end
        end else if (io.in_valid) begin
          ovf_set = 1'b1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    overflow_d = ovf_set | (overflow_q & ~clear_ovf);
  end

  always_comb begin
    buf_d = buf_q;
    if (write_en) begin
      for (int c = 0; c < 4; c++) begin
        buf_d[{write_row, c[1:0]}] = conv[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      beat_cnt_q    <= 2'd0;
      idx_q         <= 4'd0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      idx_q         <= idx_d;
      overflow_q    <= overflow_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Buffer contents are only observable in DRAIN, so they need no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

`ifdef COLLECT_SAT_EN
  logic [15:0] sat_q, sat_d;
  logic        sat_flag_q, sat_flag_d;

  always_comb begin
    sat_d = sat_q;
    if (write_en) begin
      for (int c = 0; c < 4; c++) begin
        sat_d[{write_row, c[1:0]}] = clamp[c];
      end
    end
    sat_flag_d = (hs && sat_q[idx_q]) | (sat_flag_q & ~clear_ovf);
  end

  always_ff @(posedge clk) begin
    sat_q <= sat_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign sat_flag = sat_flag_q;
`endif

  assign io.out_valid = (state_q == ST_DRAIN);
  assign io.out_data  = io.out_valid ? buf_q[idx_q] : '0;
  assign io.out_row   = idx_q[3:2];
  assign io.out_col   = idx_q[1:0];
  assign io.out_last  = io.out_valid && (idx_q == 4'hF);

  assign busy        = io.out_valid || (beat_cnt_q != 2'd0);
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tensor_result_collector.sv
// Directed bench for tensor_result_collector: table-driven basic frame plus hand-written
// sequences for backpressure, reset, overflow, width conversion and counter wrap.
module tb_tensor_result_collector;

  localparam int unsigned OUT_W = 8;
  localparam int unsigned FCW   = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear_ovf;
  logic           busy;
  logic           overflow;
  logic [FCW-1:0] frame_count;
`ifdef COLLECT_SAT_EN
  logic           sat_flag;
`endif

  tensor_result_collector_if #(.OUT_W(OUT_W)) bus ();

  tensor_result_collector #(
    .OUT_W      (OUT_W),
    .FRAME_CNT_W(FCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus),
    .busy       (busy),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .frame_count(frame_count)
`ifdef COLLECT_SAT_EN
    ,
    .sat_flag   (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             in_valid;
    logic [3:0][15:0] col;
    logic             out_ready;
    logic             exp_valid;
    logic [7:0]       exp_data;
    logic [1:0]       exp_row;
    logic [1:0]       exp_col;
    logic             exp_last;
    logic             exp_busy;
  } vec_t;

  vec_t        tbl [20];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] frame_raw [16];
  logic [7:0]  exp_e [16];
  logic [15:0] lb_cols [4];
  bit          lb_en;
  int          inj_a;
  int          inj_b;
  logic [1:0]  fc_exp;
  int          fc_seq [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_conv(input logic [15:0] v);
`ifdef COLLECT_SAT_EN
    if (v > 16'd255) return 8'hFF;
`endif
    return v[7:0];
  endfunction

  task automatic set_cols(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    bus.in_col_0 = a;
    bus.in_col_1 = b;
    bus.in_col_2 = c;
    bus.in_col_3 = d;
  endtask

  task automatic make_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      frame_raw[i] = 16'(base + 16 * (i / 4) + i % 4);
    end
    for (int i = 0; i < 16; i++) exp_e[i] = exp_conv(frame_raw[i]);
  endtask

  task automatic send_rows(input int first);
    for (int r = first; r < 4; r++) begin
      bus.in_valid = 1'b1;
      set_cols(frame_raw[4*r], frame_raw[4*r+1], frame_raw[4*r+2], frame_raw[4*r+3]);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    fc_exp = 2'd0;
  endtask

  // Drains one frame against exp_e; optional beat injections and a beat on the last handshake.
  task automatic drain(input bit stall);
    int   got;
    int   cyc;
    bit   done_a;
    bit   done_b;
    logic rdy;
    got = 0; cyc = 0; done_a = 0; done_b = 0;
    while (got < 16 && cyc < 200) begin
      chk("drain_valid", 32'(bus.out_valid), 32'd1);
      chk("drain_data",  32'(bus.out_data),  32'(exp_e[got]));
      chk("drain_row",   32'(bus.out_row),   32'(got / 4));
      chk("drain_col",   32'(bus.out_col),   32'(got % 4));
      chk("drain_last",  32'(bus.out_last),  32'(got == 15));
      rdy           = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      bus.out_ready = rdy;
      bus.in_valid  = 1'b0;
      clear_ovf     = 1'b0;
      if (got == inj_a && !done_a) begin
        bus.in_valid = 1'b1;
        set_cols(16'hDEAD, 16'hBEEF, 16'h0BAD, 16'hF00D);
        done_a = 1;
      end else if (got == inj_b && !done_b) begin
        bus.in_valid = 1'b1;
        clear_ovf    = 1'b1;
        set_cols(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        done_b = 1;
      end else if (got == 15 && rdy && lb_en) begin
        bus.in_valid = 1'b1;
        set_cols(lb_cols[0], lb_cols[1], lb_cols[2], lb_cols[3]);
      end
      @(negedge clk);
      if (rdy) got++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    clear_ovf     = 1'b0;
    bus.out_ready = 1'b0;
    chk("drain_count", 32'(got), 32'd16);
    fc_exp = fc_exp + 2'd1;
    chk("frame_count", 32'(frame_count), 32'(fc_exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    clear_ovf     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_cols(16'd0, 16'd0, 16'd0, 16'd0);
    lb_en  = 0;
    inj_a  = -1;
    inj_b  = -1;
    fc_exp = 2'd0;
    fc_seq = '{1, 2, 3, 0, 1};

    // Basic frame table: 4 beats then 16 drain cycles with out_ready held high.
    for (int r = 0; r < 4; r++) begin
      tbl[r].in_valid  = 1'b1;
      for (int c = 0; c < 4; c++) tbl[r].col[c] = 16'(16 * r + c);
      tbl[r].out_ready = 1'b1;
      tbl[r].exp_valid = (r == 3);
      tbl[r].exp_data  = 8'd0;
      tbl[r].exp_row   = 2'd0;
      tbl[r].exp_col   = 2'd0;
      tbl[r].exp_last  = 1'b0;
      tbl[r].exp_busy  = 1'b1;
    end
    for (int k = 0; k < 16; k++) begin
      int n;
      n = k + 1;
      tbl[4+k].in_valid  = 1'b0;
      tbl[4+k].col       = '0;
      tbl[4+k].out_ready = 1'b1;
      tbl[4+k].exp_valid = (k < 15);
      tbl[4+k].exp_data  = (k < 15) ? 8'(16 * (n / 4) + n % 4) : 8'd0;
      tbl[4+k].exp_row   = (k < 15) ? 2'(n / 4) : 2'd0;
      tbl[4+k].exp_col   = (k < 15) ? 2'(n % 4) : 2'd0;
      tbl[4+k].exp_last  = (n == 15);
      tbl[4+k].exp_busy  = (k < 15);
    end

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_out_data",    32'(bus.out_data),  32'd0);
    chk("rst_out_row",     32'(bus.out_row),   32'd0);
    chk("rst_out_col",     32'(bus.out_col),   32'd0);
    chk("rst_out_last",    32'(bus.out_last),  32'd0);
    chk("rst_busy",        32'(busy),          32'd0);
    chk("rst_overflow",    32'(overflow),      32'd0);
    chk("rst_frame_count", 32'(frame_count),   32'd0);
`ifdef COLLECT_SAT_EN
    chk("rst_sat_flag",    32'(sat_flag),      32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      bus.in_valid  = tbl[i].in_valid;
      set_cols(tbl[i].col[0], tbl[i].col[1], tbl[i].col[2], tbl[i].col[3]);
      bus.out_ready = tbl[i].out_ready;
      @(negedge clk);
      chk("tbl_valid", 32'(bus.out_valid), 32'(tbl[i].exp_valid));
      chk("tbl_data",  32'(bus.out_data),  32'(tbl[i].exp_data));
      chk("tbl_row",   32'(bus.out_row),   32'(tbl[i].exp_row));
      chk("tbl_col",   32'(bus.out_col),   32'(tbl[i].exp_col));
      chk("tbl_last",  32'(bus.out_last),  32'(tbl[i].exp_last));
      chk("tbl_busy",  32'(busy),          32'(tbl[i].exp_busy));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    fc_exp = 2'd1;
    chk("basic_frame_count", 32'(frame_count), 32'd1);
    chk("basic_overflow",    32'(overflow),    32'd0);

    // Backpressure: ready pattern 1,0,0,1 repeating.
    make_frame(0);
    send_rows(0);
    drain(1'b1);
    chk("bp_busy", 32'(busy), 32'd0);

    // Gapped beats at cycles 0,3,4 then reset at cycle 5; only the fresh frame drains.
    make_frame(100);
    bus.in_valid = 1'b1;
    set_cols(frame_raw[0], frame_raw[1], frame_raw[2], frame_raw[3]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    set_cols(frame_raw[4], frame_raw[5], frame_raw[6], frame_raw[7]);
    @(negedge clk);
    set_cols(frame_raw[8], frame_raw[9], frame_raw[10], frame_raw[11]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("gap_busy",  32'(busy),          32'd1);
    chk("gap_valid", 32'(bus.out_valid), 32'd0);
    do_reset();
    chk("gap_rst_busy", 32'(busy),        32'd0);
    chk("gap_rst_fc",   32'(frame_count), 32'd0);
    make_frame(200);
    send_rows(0);
    drain(1'b0);

    // Overflow: beat dropped while element 5 is presented.
    make_frame(50);
    send_rows(0);
    inj_a = 5;
    drain(1'b0);
    inj_a = -1;
    chk("ovf_set", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Beat coinciding with the final handshake becomes row 0 of the next frame.
    make_frame(0);
    send_rows(0);
    lb_cols = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    lb_en   = 1;
    drain(1'b0);
    lb_en   = 0;
    chk("lb_overflow", 32'(overflow),      32'd0);
    chk("lb_busy",     32'(busy),          32'd1);
    chk("lb_valid",    32'(bus.out_valid), 32'd0);
    make_frame(8);
    for (int c = 0; c < 4; c++) frame_raw[c] = lb_cols[c];
    for (int c = 0; c < 4; c++) exp_e[c] = exp_conv(lb_cols[c]);
    send_rows(1);
    // Set and clear in the same cycle: set wins.
    inj_a = 1;
    inj_b = 3;
    drain(1'b0);
    inj_a = -1;
    inj_b = -1;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;

    // Width conversion.
    do_reset();
    make_frame(0);
    frame_raw[0] = 16'h0393;
    frame_raw[1] = 16'h00AB;
`ifdef COLLECT_SAT_EN
    exp_e[0] = 8'hFF;
`else
    exp_e[0] = 8'h93;
`endif
    exp_e[1] = 8'hAB;
    send_rows(0);
`ifdef COLLECT_SAT_EN
    chk("sat_flag_before", 32'(sat_flag), 32'd0);
`endif
    drain(1'b0);
`ifdef COLLECT_SAT_EN
    chk("sat_flag_after", 32'(sat_flag), 32'd1);
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    chk("sat_flag_clear", 32'(sat_flag), 32'd0);
`endif

    // Counter wrap with a 2-bit frame counter.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      make_frame(f * 4);
      send_rows(0);
      drain(1'b0);
      chk("fc_wrap", 32'(frame_count), 32'(fc_seq[f]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
